uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Parametrised next-generation UART receiver. Samples the serial line at OVERSAMPLE x baud and takes a 3-sample majority vote at each bit centre. Supports 5-9 data bits, optional parity and 1 or 2 stop bits. Delivers each received word with error flags through a valid/ready output register to the downstream consumer (FIFO or bus bridge).

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate in bits/s
DATA_WIDTH, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
SYNC_STAGES, 2, synchroniser depth on rx_i; >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_i  in  1  serial line, idle high, asynchronous to clk
data_o  out  DATA_WIDTH  received word, LSB = first bit received
valid_o  out  1  data_o and the flags are valid
ready_i  in  1  consumer accepts the word when valid_o && ready_i
frame_err_o  out  1  stop bit (either stop bit if STOP_BITS=2) sampled low; qualified by valid_o
parity_err_o  out  1  parity mismatch; always 0 when PARITY=0; qualified by valid_o
overrun_o  out  1  sticky: one or more words overwritten while unaccepted
busy_o  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All flops reset asynchronously.
- Reset values: data_o=0, valid_o=0, frame_err_o=0, parity_err_o=0, overrun_o=0, busy_o=0, state=IDLE. The synchroniser flops reset to 1.
- Parameter checks: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) (integer divide) must be >= 2. Elaboration fails on DIV < 2 or on any illegal parameter value.
- Tick generator: counter 0..DIV-1. `tick` pulses when the count equals DIV-1. The counter is forced to 0 on leaving IDLE, so the tick phase aligns to the start edge.
- Sample counter: counts 0..OVERSAMPLE-1 on ticks. Samples are taken at the ticks where the count equals M-1, M and M+1, with M = OVERSAMPLE/2. The bit value is the majority of these 3 samples. The bit ends at the tick where the count equals OVERSAMPLE-1.
- Start detection: a falling edge on synchronised rx (previous 1, current 0) while in IDLE moves to START. A line held low out of reset never starts a frame.
- States:
  - IDLE -> START on falling edge.
  - START: majority 1 -> IDLE (glitch, no flag, no output). Majority 0 -> DATA at end of bit.
  - DATA: shift DATA_WIDTH bits LSB first. After the last bit -> PARITY if PARITY != 0, else STOP.
  - PARITY: compare the received bit against the computed parity. Odd parity: data bits plus parity bit contain an odd number of 1s. -> STOP at end of bit.
  - STOP: the frame is decided at the majority point of the final stop bit, then -> IDLE immediately, without waiting for the end of the bit. This allows resync on a start edge in the second half of the stop bit. For STOP_BITS=2, the first stop bit is checked at its centre and STOP runs a second bit.
- Delivery: the cycle after the final stop majority, data_o and the flags load and valid_o=1. The word is held stable until valid_o && ready_i, then valid_o=0 next cycle.
- Frames with frame or parity errors are still delivered, with their flags set.
- Overwrite: if a new word is ready while valid_o=1 and ready_i=0, the new word overwrites data_o and the flags, valid_o stays 1, and overrun_o is set to 1.
- Simultaneous delivery and accept in the same cycle: the new word loads, valid_o stays 1, and there is no overrun.
- overrun_o clears on the first handshake after it is set.
- Reset mid-frame: the frame is abandoned and no partial word is delivered.
- Latency: rx_i edge to START is SYNC_STAGES+1 cycles.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- With the macro: port break_o (out, 1, reset 0) is added. A frame whose data bits, parity bit (if any) and stop bit are all 0 is treated as a break and is not delivered. break_o=1 from that cycle until synchronised rx reads 1. The receiver stays in IDLE ignoring edges until rx has been high, then a new falling edge is required.
- Without the macro: the break_o port is absent. A break frame is delivered as data_o=0 with frame_err_o=1.

Test Plan:
- Config CLK_FREQ=32_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16 (DIV=2, 32 clk/bit), 8N1, ready_i=1. Send 0xA5 -> one valid_o pulse, data_o=0xA5, all flags 0.
- Same config with PARITY=2, send 0x3C with wrong parity bit 1 -> data_o=0x3C, parity_err_o=1. Then send 0x3C with parity 0 -> parity_err_o=0.
- ready_i=0, send 0x11 then 0x22 -> data_o=0x22, valid_o=1, overrun_o=1. Raise ready_i for 1 cycle -> valid_o=0 and overrun_o=0 next cycle.
- rx_i low pulse of 6 clocks from idle -> no valid_o, busy_o returns to 0 by the START centre. 1-clock glitch at a data-bit centre -> correct word (majority vote).
- STOP_BITS=2, 0x55 with second stop bit low -> frame_err_o=1. Assert rst_n low mid DATA -> all outputs 0 and no delivery after release.
- With UART_RX_BREAK_DETECT_EN, hold rx_i low for 12 bit-times -> break_o=1, no valid_o. Release high then send 0x7E -> break_o=0, data_o=0x7E.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, 3-sample majority vote per bit.
// Optional break detection when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_os #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  frame_err_o,
    output logic                  parity_err_o,
    output logic                  overrun_o,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                  break_o,
`endif
    output logic                  busy_o
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  SMP_LO   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SMP_MID  = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SMP_HI   = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    if (DIV < 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9 ||
        PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        SYNC_STAGES < 2) begin : g_param_check
        $error("uart_rx_os: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   rx_s;
    logic                   filled;
    logic                   rx_prev_q;
    logic                   fall;
    logic                   start_ok;

    logic [DIV_W-1:0]       div_q;
    logic [OS_W-1:0]        os_q;
    logic                   tick;
    logic                   maj_tick;
    logic                   bit_end;
    logic                   smp_lo_q;
    logic                   smp_mid_q;
    logic                   maj;

    logic [DATA_WIDTH-1:0]  shreg_q;
    logic [BIT_W-1:0]       bit_q;
    logic                   ferr_q;
    logic                   perr_q;
    logic                   par_exp;
    logic                   last_bit;
    logic                   last_stop;

    logic                   shift_en;
    logic                   bit_inc;
    logic                   bit_clr;
    logic                   par_en;
    logic                   stop1_en;
    logic                   deliver;

    logic [DATA_WIDTH-1:0]  data_q;
    logic                   valid_q;
    logic                   fe_q;
    logic                   pe_q;
    logic                   ovr_q;

    // fill_q keeps reset-time ones in the synchroniser from counting as line high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            fill_q    <= '0;
            rx_prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            if (filled) rx_prev_q <= rx_s;
        end
    end

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign filled = fill_q[SYNC_STAGES-1];
    assign fall   = filled && rx_prev_q && !rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            os_q  <= '0;
        end else if (state_q == S_IDLE) begin
            div_q <= '0;
            os_q  <= '0;
        end else if (tick) begin
            div_q <= '0;
            os_q  <= (os_q == OS_LAST) ? '0 : os_q + 1'b1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick     = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign maj_tick = tick && (os_q == SMP_HI);
    assign bit_end  = tick && (os_q == OS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_lo_q  <= 1'b1;
            smp_mid_q <= 1'b1;
        end else begin
            if (tick && os_q == SMP_LO)  smp_lo_q  <= rx_s;
            if (tick && os_q == SMP_MID) smp_mid_q <= rx_s;
        end
    end

    assign maj = (smp_lo_q & smp_mid_q) | (smp_lo_q & rx_s) |
                 (smp_mid_q & rx_s);

    assign par_exp   = (PARITY == 1) ? ~(^shreg_q) : (^shreg_q);
    assign last_bit  = (bit_q == BIT_LAST);
    assign last_stop = (STOP_BITS == 1) || (bit_q == BIT_ONE);

`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_q;
    logic brk_set;
    logic is_break;

    // parity bit recovered as perr ^ expected, so no separate flop is kept
    assign is_break = (shreg_q == '0) && !maj &&
                      (PARITY == 0 || !(perr_q ^ par_exp)) &&
                      (STOP_BITS == 1 || ferr_q);
    assign start_ok = fall && !brk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                brk_q <= 1'b0;
        else if (brk_set)          brk_q <= 1'b1;
        else if (filled && rx_s)   brk_q <= 1'b0;
    end

    assign break_o = brk_q;
`else
    assign start_ok = fall;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        bit_inc  = 1'b0;
        bit_clr  = 1'b0;
        par_en   = 1'b0;
        stop1_en = 1'b0;
        deliver  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_set  = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_START;
            end
            S_START: begin
                if (maj_tick && maj) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                    bit_clr = 1'b1;
                end
            end
            S_DATA: begin
                if (maj_tick) shift_en = 1'b1;
                if (bit_end) begin
                    if (last_bit) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                        bit_clr = 1'b1;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (maj_tick) par_en = 1'b1;
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // final stop decides at its centre to allow early resync
                if (maj_tick && last_stop) begin
                    state_d = S_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                    brk_set = is_break;
                    deliver = !is_break;
`else
                    deliver = 1'b1;
`endif
                end else if (maj_tick) begin
                    stop1_en = 1'b1;
                end else if (bit_end) begin
                    bit_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            bit_q   <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            if (shift_en) shreg_q <= {maj, shreg_q[DATA_WIDTH-1:1]};
            if (bit_clr)      bit_q <= '0;
            else if (bit_inc) bit_q <= bit_q + 1'b1;
            if (state_q == S_IDLE) begin
                ferr_q <= 1'b0;
                perr_q <= 1'b0;
            end else begin
                if (stop1_en && !maj) ferr_q <= 1'b1;
                if (par_en)           perr_q <= maj ^ par_exp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (deliver) begin
            data_q  <= shreg_q;
            fe_q    <= ferr_q | ~maj;
            pe_q    <= perr_q;
            valid_q <= 1'b1;
            if (valid_q && !ready_i)     ovr_q <= 1'b1;
            else if (valid_q && ready_i) ovr_q <= 1'b0;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = fe_q;
    assign parity_err_o = pe_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed and randomized frames on 8N1 and 8E2 receivers.
// Expected words come from a frame-level model of the line protocol.
module tb_uart_rx_os;

    localparam int BIT_CLKS = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic rdy_a = 1'b1;
    logic rdy_b = 1'b1;

    logic [7:0] a_data, b_data;
    logic a_valid, a_fe, a_pe, a_ovr, a_busy;
    logic b_valid, b_fe, b_pe, b_ovr, b_busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic a_brk, b_brk;
`endif

    int checks = 0;
    int errors = 0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLK_FREQ(32_000_000), .BAUD_RATE(1_000_000),
        .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1),
        .OVERSAMPLE(16), .SYNC_STAGES(2)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_a),
        .data_o(a_data), .valid_o(a_valid), .ready_i(rdy_a),
        .frame_err_o(a_fe), .parity_err_o(a_pe),
        .overrun_o(a_ovr),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_o(a_brk),
`endif
        .busy_o(a_busy)
    );

    uart_rx_os #(
        .CLK_FREQ(32_000_000), .BAUD_RATE(1_000_000),
        .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2),
        .OVERSAMPLE(16), .SYNC_STAGES(2)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_b),
        .data_o(b_data), .valid_o(b_valid), .ready_i(rdy_b),
        .frame_err_o(b_fe), .parity_err_o(b_pe),
        .overrun_o(b_ovr),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_o(b_brk),
`endif
        .busy_o(b_busy)
    );

    always @(negedge clk) begin
        if (a_valid && rdy_a) qa.push_back({a_fe, a_pe, a_data});
        if (b_valid && rdy_b) qb.push_back({b_fe, b_pe, b_data});
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic v);
        if (w == 0) rx_a = v;
        else        rx_b = v;
    endtask

    task automatic send_bit(input int w, input logic v, input bit gl);
        if (gl) begin
            drive(w, v);  cyc(18);
            drive(w, ~v); cyc(1);
            drive(w, v);  cyc(BIT_CLKS - 19);
        end else begin
            drive(w, v);  cyc(BIT_CLKS);
        end
    endtask

    function automatic logic even_bit(input logic [7:0] d);
        return (($countones(d) % 2) == 1);
    endfunction

    // w=0: 8N1 line, w=1: 8E2 line
    task automatic send_frame(input int w, input logic [7:0] d,
                              input logic pflip, input logic [1:0] st,
                              input int gl_bit);
        send_bit(w, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(w, d[i], gl_bit == i);
        if (w == 1) send_bit(w, even_bit(d) ^ pflip, 1'b0);
        send_bit(w, st[0], 1'b0);
        if (w == 1) send_bit(w, st[1], 1'b0);
        drive(w, 1'b1);
        cyc(2 * BIT_CLKS);
    endtask

    function automatic logic [9:0] model(input int w, input logic [7:0] d,
                                         input logic pflip,
                                         input logic [1:0] st);
        logic fe, pe;
        if (w == 0) begin
            fe = !st[0];
            pe = 1'b0;
        end else begin
            fe = !(st[0] && st[1]);
            pe = pflip;
        end
        return {fe, pe, d};
    endfunction

    task automatic expect_word(input int w, input logic [9:0] e,
                               input string tag);
        int n;
        logic [9:0] got;
        n = (w == 0) ? qa.size() : qb.size();
        check({tag, "_cnt"}, n, 1);
        if (n > 0) begin
            if (w == 0) got = qa.pop_front();
            else        got = qb.pop_front();
            check(tag, got, e);
        end
        if (w == 0) qa.delete();
        else        qb.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] st;
        logic       pf;
        int         gb;

        cyc(5);
        check("rst_a_valid", a_valid, 0);
        check("rst_a_data", a_data, 0);
        check("rst_a_flags", {a_fe, a_pe, a_ovr}, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_busy", b_busy, 0);
`ifdef UART_RX_BREAK_DETECT_EN
        check("rst_a_brk", a_brk, 0);
`endif
        rst_n = 1'b1;
        cyc(10);

        send_frame(0, 8'hA5, 1'b0, 2'b11, -1);
        expect_word(0, {2'b00, 8'hA5}, "a5");
        check("a5_ovr", a_ovr, 0);

        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom);
            st = {1'b1, 1'($urandom_range(3) != 0)};
            if (d == 8'h00) st = 2'b11;
            send_frame(0, d, 1'b0, st, -1);
            expect_word(0, model(0, d, 1'b0, st), "rnd_a");
        end

        send_frame(1, 8'h3C, 1'b1, 2'b11, -1);
        expect_word(1, {2'b01, 8'h3C}, "par_bad");
        send_frame(1, 8'h3C, 1'b0, 2'b11, -1);
        expect_word(1, {2'b00, 8'h3C}, "par_ok");

        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom);
            pf = 1'($urandom_range(1));
            st = 2'($urandom_range(3));
            if ($urandom_range(1) == 1) st = 2'b11;
            if (d == 8'h00) st = 2'b11;
            send_frame(1, d, pf, st, -1);
            expect_word(1, model(1, d, pf, st), "rnd_b");
        end

        send_frame(1, 8'h55, 1'b0, 2'b01, -1);
        expect_word(1, {2'b10, 8'h55}, "stop2_low");

        for (int i = 0; i < 3; i++) begin
            d  = 8'($urandom);
            gb = $urandom_range(7);
            send_frame(0, d, 1'b0, 2'b11, gb);
            expect_word(0, model(0, d, 1'b0, 2'b11), "glitch");
        end

        drive(0, 1'b0); cyc(6);
        drive(0, 1'b1); cyc(4);
        check("pulse_busy_hi", a_busy, 1);
        cyc(30);
        check("pulse_busy_lo", a_busy, 0);
        check("pulse_nowrd", qa.size(), 0);
        cyc(BIT_CLKS);

        rdy_a = 1'b0;
        send_frame(0, 8'h11, 1'b0, 2'b11, -1);
        send_frame(0, 8'h22, 1'b0, 2'b11, -1);
        check("ovr_valid", a_valid, 1);
        check("ovr_data", a_data, 8'h22);
        check("ovr_flag", a_ovr, 1);
        check("ovr_fe", a_fe, 0);
        rdy_a = 1'b1;
        cyc(1);
        rdy_a = 1'b0;
        check("ovr_clr_valid", a_valid, 0);
        check("ovr_clr_flag", a_ovr, 0);
        cyc(2);
        rdy_a = 1'b1;
        expect_word(0, {2'b00, 8'h22}, "ovr_word");

        drive(0, 1'b0);
        cyc(12 * BIT_CLKS);
`ifdef UART_RX_BREAK_DETECT_EN
        check("brk_set", a_brk, 1);
        check("brk_nowrd", qa.size(), 0);
        check("brk_valid", a_valid, 0);
        drive(0, 1'b1);
        cyc(8);
        check("brk_clr", a_brk, 0);
`else
        expect_word(0, {2'b10, 8'h00}, "brk_word");
        drive(0, 1'b1);
        cyc(8);
`endif
        cyc(2 * BIT_CLKS);
        send_frame(0, 8'h7E, 1'b0, 2'b11, -1);
        expect_word(0, {2'b00, 8'h7E}, "post_brk");
`ifdef UART_RX_BREAK_DETECT_EN
        check("post_brk_flag", a_brk, 0);
`endif

        drive(1, 1'b0); cyc(BIT_CLKS);
        drive(1, 1'b1); cyc(3 * BIT_CLKS);
        check("mid_busy", b_busy, 1);
        rst_n = 1'b0;
        cyc(2);
        check("mid_rst_valid", b_valid, 0);
        check("mid_rst_busy", b_busy, 0);
        check("mid_rst_data", b_data, 0);
        check("mid_rst_flags", {b_fe, b_pe, b_ovr}, 0);
        check("mid_rst_a", {a_valid, a_busy}, 0);
        rst_n = 1'b1;
        cyc(9 * BIT_CLKS + 2 * BIT_CLKS);
        check("mid_nowrd", qb.size(), 0);
        check("mid_idle", {b_valid, b_busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
